// File: rtl/soc2_sysid_checker.sv
// Boot-time identity verifier: reads SYSID word 0 (ID) and word 1 (timestamp) over
// Avalon-MM, compares both against expected constants and publishes status flags.
module soc2_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1729829009,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [2:0]  state_dbg
);

  // Avalon read handshake: m_read acts as valid, !m_waitrequest as ready. A word
  // transfers on a cycle with m_read=1 and m_waitrequest=0; until then m_read and
  // m_address stay constant.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       armed;
  logic [7:0] wait_cnt;
  logic       run_entry;
  logic       stall_expired;

  assign state_dbg = state_q;

  always_comb begin
    state_d       = state_q;
    run_entry     = 1'b0;
    stall_expired = m_waitrequest && (wait_cnt == TIMEOUT_CYCLES);
    case (state_q)
      IDLE: begin
        // armed is clear only in the first cycle after reset release
        if (start || (AUTO_START && !armed)) begin
          state_d   = RD_ID;
          run_entry = 1'b1;
        end
      end
      RD_ID: begin
        if (!m_waitrequest) begin
          state_d = RD_TS;
        end else if (stall_expired) begin
          state_d = DONE;
        end
      end
      RD_TS: begin
        if (!m_waitrequest) begin
          state_d = CHECK;
        end else if (stall_expired) begin
          state_d = DONE;
        end
      end
      CHECK: begin
        state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d   = RD_ID;
          run_entry = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      armed   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed   <= 1'b1;
    end
  end

  // Bus strobes and busy are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_read    <= 1'b0;
      m_address <= 1'b0;
      busy      <= 1'b0;
    end else begin
      m_read    <= (state_d == RD_ID) || (state_d == RD_TS);
      m_address <= (state_d == RD_TS);
      busy      <= (state_d == RD_ID) || (state_d == RD_TS) || (state_d == CHECK);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= 8'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
    end else if (run_entry) begin
      wait_cnt    <= 8'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state_q)
        RD_ID: begin
          if (!m_waitrequest) begin
            captured_id <= m_readdata;
            wait_cnt    <= 8'd0;
          end else if (stall_expired) begin
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RD_TS: begin
          if (!m_waitrequest) begin
            captured_ts <= m_readdata;
            wait_cnt    <= 8'd0;
          end else if (stall_expired) begin
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        CHECK: begin
          id_mismatch <= (captured_id != EXPECTED_ID);
          ts_mismatch <= (captured_ts != EXPECTED_TS);
          pass        <= (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TS);
        end
        DONE: begin
          // done rises one cycle after the flags settle, so flags are stable when seen
          done <= 1'b1;
        end
        default: begin
          wait_cnt <= wait_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc2_sysid_checker.sv
// Directed bench for soc2_sysid_checker: expected results are queued per run and a
// monitor pops/compares them whenever done rises.
module tb_soc2_sysid_checker;

  localparam logic [31:0] EXP_TS = 32'd1729829009;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // main DUT (defaults: AUTO_START=1, TIMEOUT_CYCLES=255)
  logic        start = 1'b0;
  logic        m_address, m_read, m_waitrequest;
  logic [31:0] m_readdata;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] captured_id, captured_ts;
  logic [2:0]  state_dbg;

  soc2_sysid_checker dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .busy(busy), .done(done), .pass(pass),
    .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch), .timeout(timeout),
    .captured_id(captured_id), .captured_ts(captured_ts), .state_dbg(state_dbg)
  );

  // second DUT: manual start, short timeout
  logic        start2 = 1'b0;
  logic        m_address2, m_read2, m_waitrequest2;
  logic [31:0] m_readdata2;
  logic        busy2, done2, pass2, id_mismatch2, ts_mismatch2, timeout2;
  logic [31:0] captured_id2, captured_ts2;
  logic [2:0]  state_dbg2;
  logic        stuck2 = 1'b0;

  soc2_sysid_checker #(.TIMEOUT_CYCLES(8'd4), .AUTO_START(1'b0)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2),
    .m_address(m_address2), .m_read(m_read2), .m_readdata(m_readdata2),
    .m_waitrequest(m_waitrequest2), .busy(busy2), .done(done2), .pass(pass2),
    .id_mismatch(id_mismatch2), .ts_mismatch(ts_mismatch2), .timeout(timeout2),
    .captured_id(captured_id2), .captured_ts(captured_ts2), .state_dbg(state_dbg2)
  );

  assign m_readdata2    = m_address2 ? EXP_TS : 32'h0;
  assign m_waitrequest2 = m_read2 && m_address2 && stuck2;

  // slave model for main DUT: wait_n stall cycles before each accepted read
  logic [31:0] id_val = 32'h0;
  logic [31:0] ts_val = EXP_TS;
  logic [3:0]  wait_n = 4'd0;
  logic [3:0]  ws_cnt = 4'd0;
  int          rd_count = 0;

  assign m_readdata    = m_address ? ts_val : id_val;
  assign m_waitrequest = m_read && (ws_cnt < wait_n);

  always @(posedge clock) begin
    if (!m_read || !m_waitrequest) ws_cnt <= 4'd0;
    else ws_cnt <= ws_cnt + 4'd1;
    if (m_read && !m_waitrequest) rd_count <= rd_count + 1;
  end

  // scoreboard: {id_mm, ts_mm, pass, timeout, cap_id, cap_ts, latency}
  logic [75:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic idm, input logic tsm, input logic ps,
                          input logic [31:0] cid, input logic [31:0] cts, input logic [7:0] lat);
    exp_q.push_back({idm, tsm, ps, 1'b0, cid, cts, lat});
  endtask

  // monitor
  int          cyc = 0;
  int          t_busy = 0;
  logic        busy_prev = 1'b0, done_prev = 1'b0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0, prev_addr = 1'b0, prev_rstn = 1'b0;
  logic [75:0] e;

  always @(negedge clock) begin
    cyc++;
    if (busy && !busy_prev) t_busy = cyc;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("id_mismatch", {31'd0, id_mismatch}, {31'd0, e[75]});
        check("ts_mismatch", {31'd0, ts_mismatch}, {31'd0, e[74]});
        check("pass", {31'd0, pass}, {31'd0, e[73]});
        check("timeout", {31'd0, timeout}, {31'd0, e[72]});
        check("captured_id", captured_id, e[71:40]);
        check("captured_ts", captured_ts, e[39:8]);
        check("done_latency", cyc - t_busy, {24'd0, e[7:0]});
      end
    end
    if (reset_n && prev_rstn && prev_rd && prev_wr) begin
      check("stall_read_held", {31'd0, m_read}, 32'd1);
      check("stall_addr_held", {31'd0, m_address}, {31'd0, prev_addr});
    end
    busy_prev = busy;
    done_prev = done;
    prev_rd   = m_read;
    prev_wr   = m_waitrequest;
    prev_addr = m_address;
    prev_rstn = reset_n;
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic pulse_start2();
    @(negedge clock) start2 = 1'b1;
    @(negedge clock) start2 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) break;
    end
    check("run_complete", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_rd_ts();
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (m_read && m_address) break;
    end
    check("reached_rd_ts", {31'd0, m_read && m_address}, 32'd1);
  endtask

  task automatic wait_done2();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done2) break;
    end
    check("done2_reached", {31'd0, done2}, 32'd1);
  endtask

  int rc0;
  int stall2;

  initial begin
    // reset state
    repeat (2) @(negedge clock);
    check("rst_m_read", {31'd0, m_read}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);

    // 1: auto start after release, clean slave
    push_exp(1'b0, 1'b0, 1'b1, 32'h0, EXP_TS, 8'd4);
    rc0 = rd_count;
    reset_n = 1'b1;
    wait_drain();
    check("s1_reads", rd_count - rc0, 32'd2);
    check("s1_dut2_idle_busy", {31'd0, busy2}, 32'd0);
    check("s1_dut2_idle_done", {31'd0, done2}, 32'd0);

    // 2: ID mismatch, then fixed slave with flags cleared on entry
    id_val = 32'h1;
    push_exp(1'b1, 1'b0, 1'b0, 32'h1, EXP_TS, 8'd4);
    pulse_start();
    wait_drain();
    id_val = 32'h0;
    push_exp(1'b0, 1'b0, 1'b1, 32'h0, EXP_TS, 8'd4);
    pulse_start();
    check("s2_entry_done_clr", {31'd0, done}, 32'd0);
    check("s2_entry_idmm_clr", {31'd0, id_mismatch}, 32'd0);
    check("s2_entry_busy", {31'd0, busy}, 32'd1);
    check("s2_entry_capid_kept", captured_id, 32'h1);
    wait_drain();

    // 3: three wait states per read
    wait_n = 4'd3;
    rc0 = rd_count;
    push_exp(1'b0, 1'b0, 1'b1, 32'h0, EXP_TS, 8'd10);
    pulse_start();
    wait_drain();
    check("s3_reads", rd_count - rc0, 32'd2);
    wait_n = 4'd0;

    // 5: start pulsed during RD_TS is ignored
    rc0 = rd_count;
    push_exp(1'b0, 1'b0, 1'b1, 32'h0, EXP_TS, 8'd4);
    pulse_start();
    wait_rd_ts();
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    wait_drain();
    repeat (10) @(negedge clock);
    check("s5_reads", rd_count - rc0, 32'd2);
    check("s5_busy_idle", {31'd0, busy}, 32'd0);
    check("s5_done_held", {31'd0, done}, 32'd1);

    // 6: reset mid-run in RD_TS, then fresh automatic run
    rc0 = rd_count;
    ts_val = 32'h1234_5678;
    pulse_start();
    wait_rd_ts();
    reset_n = 1'b0;
    #1;
    check("s6_rst_m_read", {31'd0, m_read}, 32'd0);
    check("s6_rst_busy", {31'd0, busy}, 32'd0);
    check("s6_rst_done", {31'd0, done}, 32'd0);
    check("s6_rst_pass", {31'd0, pass}, 32'd0);
    check("s6_rst_cap_ts", captured_ts, 32'd0);
    ts_val = EXP_TS;
    push_exp(1'b0, 1'b0, 1'b1, 32'h0, EXP_TS, 8'd4);
    @(negedge clock) reset_n = 1'b1;
    wait_drain();
    check("s6_reads", rd_count - rc0, 32'd3);

    // 4: timeout on dut2 (TIMEOUT_CYCLES=4) after a good run
    pulse_start2();
    wait_done2();
    check("s4_good_pass", {31'd0, pass2}, 32'd1);
    check("s4_good_cap_ts", captured_ts2, EXP_TS);
    stuck2 = 1'b1;
    stall2 = 0;
    pulse_start2();
    for (int i = 0; i < 100; i++) begin
      if (m_read2 && m_waitrequest2) stall2++;
      if (done2) break;
      @(negedge clock);
    end
    check("s4_done", {31'd0, done2}, 32'd1);
    check("s4_timeout", {31'd0, timeout2}, 32'd1);
    check("s4_pass", {31'd0, pass2}, 32'd0);
    check("s4_idmm", {31'd0, id_mismatch2}, 32'd0);
    check("s4_tsmm", {31'd0, ts_mismatch2}, 32'd0);
    check("s4_m_read", {31'd0, m_read2}, 32'd0);
    check("s4_cap_ts_kept", captured_ts2, EXP_TS);
    check("s4_stall_cycles", stall2, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
